// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver: UART receive framing stage.
// Synchronizes the Rx line, flags start-bit falling edges, and deserializes
// one frame (start, DATA_BITS data LSB-first, optional parity, one stop bit)
// using externally generated mid-bit sampling strobes.
// Optional feature: define RX_PARITY_EN to compile in the even-parity bit.
module rx_frame_receiver #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   input  logic                 sampling_strobe,
   output logic                 start_detected,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 parity_error
);

   localparam int CW = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_prev;
   logic [CW-1:0]        bit_count;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 fall_edge;
   logic                 last_bit;

   // A start is a 1->0 transition of the synchronized line, so a held-low
   // break never retriggers.
   assign fall_edge = rx_prev & ~rx_sync;
   assign last_bit  = (bit_count == CW'(DATA_BITS - 1));

   // Two-flop synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= serial_in;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic; strobes are ignored in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (fall_edge) state_next = START;
         START: if (sampling_strobe) state_next = rx_sync ? IDLE : DATA;
         DATA: begin
            if (sampling_strobe && last_bit) begin
`ifdef RX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef RX_PARITY_EN
         PARITY: if (sampling_strobe) state_next = STOP;
`endif
         STOP:  if (sampling_strobe) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: start pulse, shift register, bit counter and frame outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_detected <= 1'b0;
         data_out       <= '0;
         data_valid     <= 1'b0;
         framing_error  <= 1'b0;
         shift_reg      <= '0;
         bit_count      <= '0;
      end else begin
         start_detected <= (state_reg == IDLE) && fall_edge;
         data_valid     <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (fall_edge) bit_count <= '0;
            end
            DATA: begin
               if (sampling_strobe) begin
                  shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                  bit_count <= bit_count + CW'(1);
               end
            end
            STOP: begin
               if (sampling_strobe) begin
                  data_out      <= shift_reg;
                  data_valid    <= 1'b1;
                  framing_error <= ~rx_sync;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RX_PARITY_EN
   logic parity_bad;

   // Even parity: data ones plus parity bit must be even; the flag is
   // published only when the frame completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_bad   <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         if (state_reg == PARITY && sampling_strobe)
            parity_bad <= rx_sync ^ (^shift_reg);
         if (state_reg == STOP && sampling_strobe)
            parity_error <= parity_bad;
      end
   end
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Testbench for rx_frame_receiver with a behavioural mid-bit strobe model
// and a scoreboard of expected frames checked on every data_valid pulse.
module tb_rx_frame_receiver;

   localparam int DATA_BITS = 8;
   localparam int CPB       = 8;
`ifdef RX_PARITY_EN
   localparam int PBIT = 1;
`else
   localparam int PBIT = 0;
`endif
   localparam int FRAME_STROBES = 2 + DATA_BITS + PBIT;

   logic                 clk;
   logic                 reset;
   logic                 serial_in;
   logic                 sampling_strobe;
   logic                 start_detected;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 framing_error;
   logic                 parity_error;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total       = 0;
   int   bad         = 0;
   int   valid_count = 0;
   int   start_count = 0;
   logic prev_valid  = 1'b0;

   rx_frame_receiver #(.DATA_BITS(DATA_BITS)) dut (
      .clk            (clk),
      .reset          (reset),
      .serial_in      (serial_in),
      .sampling_strobe(sampling_strobe),
      .start_detected (start_detected),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .framing_error  (framing_error),
      .parity_error   (parity_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe model: first strobe half a bit after start_detected, then one per bit.
   initial begin
      sampling_strobe = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (start_detected === 1'b1) begin
            repeat (CPB / 2) @(posedge clk);
            #1 sampling_strobe = 1'b1;
            @(posedge clk); #1 sampling_strobe = 1'b0;
            for (int i = 1; i < FRAME_STROBES; i++) begin
               repeat (CPB - 1) @(posedge clk);
               #1 sampling_strobe = 1'b1;
               @(posedge clk); #1 sampling_strobe = 1'b0;
            end
         end
      end
   end

   // Output monitor: scoreboard compare on each data_valid, pulse width check.
   initial begin
      forever begin
         @(negedge clk);
         if (start_detected === 1'b1) start_count++;
         if (data_valid === 1'b1) begin
            valid_count++;
            total++;
            if (prev_valid === 1'b1) begin
               bad++;
               $display("FAIL valid_width: data_valid high %0d cycles in a row, required 1", 2);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid: got data=%h fe=%b pe=%b, required no output",
                        data_out, framing_error, parity_error);
            end else begin
               e = exp_q.pop_front();
               if ({data_out, framing_error, parity_error} !== {e.d, e.fe, e.pe}) begin
                  bad++;
                  $display("FAIL frame: got data=%h fe=%b pe=%b, required data=%h fe=%b pe=%b",
                           data_out, framing_error, parity_error, e.d, e.fe, e.pe);
               end
               $display("frame data=%h fe=%b pe=%b", data_out, framing_error, parity_error);
            end
         end
         prev_valid = data_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Drive n line bits LSB first, CPB cycles each; optionally check start latency.
   task automatic send_bits(input logic [15:0] bits, input int n, input bit chk);
      for (int b = 0; b < n; b++) begin
         serial_in = bits[b];
         for (int c = 0; c < CPB; c++) begin
            @(posedge clk); #1;
            if (chk && b == 0 && c < 4) begin
               total++;
               if (start_detected !== logic'(c == 2)) begin
                  bad++;
                  $display("FAIL start_latency: cycle %0d got %b, required %b",
                           c + 1, start_detected, (c == 2));
               end
            end
         end
      end
   endtask

   task automatic make_frame(input logic [7:0] d, input logic stop, output logic [15:0] bits);
      bits      = 16'hFFFF;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (PBIT == 1) begin
         bits[9]  = ^d;
         bits[10] = stop;
      end else begin
         bits[9] = stop;
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
      exp_t x;
      x.d  = d;
      x.fe = fe;
      x.pe = pe;
      exp_q.push_back(x);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: %0d frames outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      serial_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      serial_in = 1'b1;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total += 5;
      if (start_detected !== 1'b0) begin bad++; $display("FAIL reset_start: got %b required 0", start_detected); end
      if (data_out !== 8'h00)      begin bad++; $display("FAIL reset_data: got %h required 00", data_out); end
      if (data_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %b required 0", data_valid); end
      if (framing_error !== 1'b0)  begin bad++; $display("FAIL reset_fe: got %b required 0", framing_error); end
      if (parity_error !== 1'b0)   begin bad++; $display("FAIL reset_pe: got %b required 0", parity_error); end
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_good_frame();
      logic [15:0] bits;
      int s0;
      s0 = start_count;
      make_frame(8'hA5, 1'b1, bits);
      push_exp(8'hA5, 1'b0, 1'b0);
      send_bits(bits, FRAME_STROBES, 1'b1);
      drain("good");
      total++;
      if (start_count - s0 != 1) begin
         bad++;
         $display("FAIL good_start_count: got %0d required 1", start_count - s0);
      end
   endtask

   task automatic test_false_start();
      int s0, v0;
      s0 = start_count;
      v0 = valid_count;
      serial_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 serial_in = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      total += 4;
      if (start_count - s0 != 1) begin bad++; $display("FAIL false_start_pulse: got %0d required 1", start_count - s0); end
      if (valid_count != v0)     begin bad++; $display("FAIL false_start_valid: got %0d pulses required 0", valid_count - v0); end
      if ({framing_error, parity_error} !== 2'b00) begin
         bad++; $display("FAIL false_start_flags: got %b%b required 00", framing_error, parity_error);
      end
      if (data_out !== 8'hA5) begin bad++; $display("FAIL false_start_data: got %h required a5", data_out); end
      // Receiver must still take a normal frame afterwards.
      push_exp(8'h96, 1'b0, 1'b0);
      begin
         logic [15:0] bits;
         make_frame(8'h96, 1'b1, bits);
         send_bits(bits, FRAME_STROBES, 1'b0);
      end
      drain("after_false");
   endtask

   task automatic test_framing();
      logic [15:0] bits;
      make_frame(8'h3C, 1'b0, bits);
      push_exp(8'h3C, 1'b1, 1'b0);
      send_bits(bits, FRAME_STROBES, 1'b0);
      drain("framing_bad");
      total++;
      if (framing_error !== 1'b1) begin bad++; $display("FAIL framing_hold: got %b required 1", framing_error); end
      make_frame(8'h11, 1'b1, bits);
      push_exp(8'h11, 1'b0, 1'b0);
      send_bits(bits, FRAME_STROBES, 1'b0);
      drain("framing_good");
   endtask

   task automatic test_parity();
      logic [15:0] bits;
      bits      = 16'hFFFF;
      bits[0]   = 1'b0;
      bits[8:1] = 8'h01;
      bits[9]   = 1'b0;
      if (PBIT == 1) push_exp(8'h01, 1'b0, 1'b1);
      else           push_exp(8'h01, 1'b1, 1'b0);
      send_bits(bits, 11, 1'b0);
      drain("parity");
   endtask

   task automatic test_reset_mid();
      logic [15:0] bits;
      int v0;
      v0 = valid_count;
      make_frame(8'hFF, 1'b1, bits);
      send_bits(bits, 5, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total += 4;
      if (data_out !== 8'h00)     begin bad++; $display("FAIL midreset_data: got %h required 00", data_out); end
      if (framing_error !== 1'b0) begin bad++; $display("FAIL midreset_fe: got %b required 0", framing_error); end
      if (parity_error !== 1'b0)  begin bad++; $display("FAIL midreset_pe: got %b required 0", parity_error); end
      if (start_detected !== 1'b0) begin bad++; $display("FAIL midreset_start: got %b required 0", start_detected); end
      serial_in = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      total++;
      if (valid_count != v0) begin bad++; $display("FAIL midreset_valid: got %0d pulses required 0", valid_count - v0); end
      make_frame(8'h5A, 1'b1, bits);
      push_exp(8'h5A, 1'b0, 1'b0);
      send_bits(bits, FRAME_STROBES, 1'b0);
      drain("after_reset");
   endtask

   task automatic test_back_to_back();
      logic [15:0] b0, b1;
      int v0;
      v0 = valid_count;
      make_frame(8'h00, 1'b1, b0);
      make_frame(8'hFF, 1'b1, b1);
      push_exp(8'h00, 1'b0, 1'b0);
      push_exp(8'hFF, 1'b0, 1'b0);
      send_bits(b0, FRAME_STROBES, 1'b0);
      send_bits(b1, FRAME_STROBES, 1'b0);
      drain("b2b");
      total++;
      if (valid_count - v0 != 2) begin bad++; $display("FAIL b2b_count: got %0d pulses required 2", valid_count - v0); end
   endtask

   initial begin
      reset     = 1'b1;
      serial_in = 1'b1;
      test_reset();
      test_good_frame();
      test_false_start();
      test_framing();
      test_parity();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
